seq_divider: RTL and testbench

Multi-cycle 32-bit integer divider that executes MIPS DIV/DIVU by restoring (shift/subtract) division, one quotient bit per clock. It sits beside the ALU in the execute stage. The pipeline control stalls on `busy`, then writes `quotient` into LO and `remainder` into HI when `done` pulses. Trial subtraction reuses the datapath's adder style: A + ~B + 1 through a single (WIDTH+1)-bit adder.

---
 rtl/seq_divider_if.sv | 26 ++
 rtl/seq_divider.sv | 150 +++++++++++++++
 tb/tb_seq_divider.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle between the pipeline control and the sequential divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    // Pipeline side: issues requests, consumes results.
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift/subtract divider for MIPS DIV/DIVU, one quotient bit per clock.
// Fixed latency WIDTH+1 cycles from the accepting edge, divide-by-zero included.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    seq_divider_if.slave  bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quo_q, quo_d;         // dividend magnitude, quotient bits shift in at LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
    logic [WIDTH:0]   rem_q, rem_d;         // partial remainder
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             signed_q, signed_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] orig_q, orig_d;       // untouched dividend for the divide-by-zero result
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] sum;
    logic             carry;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             unused_rem_msb;

    // The partial remainder stays below the divisor, so its top bit never feeds the next shift.
    assign unused_rem_msb = rem_q[WIDTH];

    // Trial subtraction A + ~B + 1; the carry out flags a non-negative result.
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign sum     = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry   = sum[WIDTH+1];

    assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
    assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];

    // Sign correction: quotient negative on operand sign mismatch, remainder follows dividend.
    assign q_fix = (signed_q & neg_quo_q) ? (WIDTH'(0) - quo_q) : quo_q;
    assign r_fix = (signed_q & neg_rem_q) ? (WIDTH'(0) - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    // Next-state, datapath and result logic.
    always_comb begin
        state_d     = state_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        signed_d    = signed_q;
        zero_d      = zero_q;
        orig_d      = orig_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    quo_d     = a_neg ? (WIDTH'(0) - bus.dividend) : bus.dividend;
                    dvs_d     = b_neg ? (WIDTH'(0) - bus.divisor) : bus.divisor;
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
                    signed_d  = bus.is_signed;
                    zero_d    = (bus.divisor == '0);
                    orig_d    = bus.dividend;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                quo_d = {quo_q[WIDTH-2:0], carry};
                rem_d = carry ? sum[WIDTH:0] : shifted;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = orig_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = q_fix;
                    remainder_d = r_fix;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            quo_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            signed_q    <= 1'b0;
            zero_q      <= 1'b0;
            orig_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            signed_q    <= signed_d;
            zero_q      <= zero_d;
            orig_q      <= orig_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          launched = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // MIPS DIV/DIVU semantics from plain integer arithmetic (truncating division).
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic [31:0] z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 0;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    // One operation: accept at E0, done expected in the 34th sampled cycle after E0.
    task automatic run_op(input string tag, input bit s, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input bit chain,
                          input bit ns, input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] eq, er, ez;
        int          busy_cnt = 0;
        int          done_at  = 0;
        ref_div(s, a, b, eq, er, ez);
        if (!launched) begin
            @(negedge clk);
            bus.start     = 1'b1;
            bus.is_signed = s;
            bus.dividend  = a;
            bus.divisor   = b;
        end
        launched = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (disturb && n == 10) begin
                bus.start     = 1'b1;
                bus.is_signed = ~s;
                bus.dividend  = $urandom;
                bus.divisor   = $urandom;
            end
            if (disturb && n == 11) bus.start = 1'b0;
            if (bus.done) begin
                done_at = n;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        check_eq({tag, " latency"}, done_at, 34);
        check_eq({tag, " busy_cycles"}, busy_cnt, 33);
        check_eq({tag, " busy_in_done"}, {31'd0, bus.busy}, 0);
        check_eq({tag, " quotient"}, bus.quotient, eq);
        check_eq({tag, " remainder"}, bus.remainder, er);
        check_eq({tag, " div_by_zero"}, {31'd0, bus.div_by_zero}, ez);
        if (chain) begin
            bus.start     = 1'b1;
            bus.is_signed = ns;
            bus.dividend  = na;
            bus.divisor   = nb;
            launched      = 1'b1;
        end else begin
            @(negedge clk);
            check_eq({tag, " done_pulse"}, {31'd0, bus.done}, 0);
            check_eq({tag, " hold_q"}, bus.quotient, eq);
            check_eq({tag, " hold_r"}, bus.remainder, er);
        end
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'($urandom_range(0, 200));
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 15));
            3: begin
                v = $urandom;
                return v >> $urandom_range(0, 31);
            end
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int dcnt;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset busy", {31'd0, bus.busy}, 0);
        check_eq("reset done", {31'd0, bus.done}, 0);
        check_eq("reset quotient", bus.quotient, 0);
        check_eq("reset remainder", bus.remainder, 0);
        check_eq("reset dbz", {31'd0, bus.div_by_zero}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu 100/7", 0, 32'd100, 32'd7, 0, 0, 0, 0, 0);
        run_op("div -7/2", 1, -32'sd7, 32'd2, 0, 0, 0, 0, 0);
        run_op("div 7/-2", 1, 32'd7, -32'sd2, 0, 0, 0, 0, 0);
        run_op("div -7/-2", 1, -32'sd7, -32'sd2, 0, 0, 0, 0, 0);
        run_op("div ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op("divu min/-1", 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        run_op("divu max/1", 0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0);
        run_op("divu 5/0", 0, 32'd5, 32'd0, 0, 0, 0, 0, 0);
        run_op("div -5/0", 1, -32'sd5, 32'd0, 0, 0, 0, 0, 0);
        run_op("divu 9/3", 0, 32'd9, 32'd3, 0, 0, 0, 0, 0);
        run_op("disturbed 100/7", 0, 32'd100, 32'd7, 1, 0, 0, 0, 0);
        run_op("chain first", 1, 32'd1000, -32'sd3, 0, 1, 0, 32'd12345, 32'd11);
        run_op("chain second", 0, 32'd12345, 32'd11, 0, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            bit          s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = pick_a();
            b = pick_b();
            run_op($sformatf("rand%0d %0s %08h/%08h", i, s ? "div" : "divu", a, b),
                   s, a, b, 0, 0, 0, 0, 0);
        end

        // Abort mid-run: leaves a nonzero previous result so the clear is visible.
        run_op("pre-reset 1000/3", 0, 32'd1000, 32'd3, 0, 0, 0, 0, 0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd123456;
        bus.divisor   = 32'd7;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (11) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst busy", {31'd0, bus.busy}, 0);
        check_eq("midrst done", {31'd0, bus.done}, 0);
        check_eq("midrst quotient", bus.quotient, 0);
        check_eq("midrst remainder", bus.remainder, 0);
        check_eq("midrst dbz", {31'd0, bus.div_by_zero}, 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        check_eq("midrst no_done", dcnt, 0);
        run_op("post-reset 50/5", 0, 32'd50, 32'd5, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
